// File: rtl/tmem_read_arbiter_pkg.sv
// Shared definitions for the TMEM read arbiter and its round-robin selector.
// The selector is also used by the OMEM write arbiter.
package tmem_read_arbiter_pkg;

    localparam int DATA_ROW_WIDTH = 96;
    localparam int MAX_CORES      = 4;

    typedef enum logic [1:0] {
        TMARB_IDLE       = 2'd0,
        TMARB_ISSUE_WAIT = 2'd1,
        TMARB_RESPOND    = 2'd2,
        TMARB_DRAIN      = 2'd3
    } tmarb_state_e;

    // Successor of an index in a ring of 'modulus' entries.
    function automatic int wrapIncrement(input int value, input int modulus);
        return (value + 1 >= modulus) ? 0 : value + 1;
    endfunction

endpackage

// File: rtl/tmem_read_arbiter_rr_select.sv
// Combinational round-robin search: returns the first requester at or after
// the pointer, wrapping past the top index back to zero.
module rr_priority_select #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             grant_valid_o,
    output logic [IDX_W-1:0] grant_index_o
);

    int               cand;
    logic [IDX_W-1:0] candIdx;

    // Walk from the farthest offset down so the nearest requester wins last.
    always_comb begin
        grant_valid_o = 1'b0;
        grant_index_o = '0;
        cand          = 0;
        candIdx       = '0;
        for (int off = N - 1; off >= 0; off--) begin
            cand = int'(ptr_i) + off;
            if (cand >= N) begin
                cand = cand - N;
            end
            candIdx = IDX_W'(cand);
            if (req_i[candIdx]) begin
                grant_valid_o = 1'b1;
                grant_index_o = candIdx;
            end
        end
    end

endmodule

// File: rtl/tmem_read_arbiter.sv
// Shares the single TMEM read port among the execution cores: one round-robin
// grant at a time, 4-phase handshake towards both the cores and TMEM.
module tmem_read_arbiter
    import tmem_read_arbiter_pkg::*;
#(
    parameter int NUM_CORES = MAX_CORES,
    parameter int ADDR_W    = DATA_ROW_WIDTH,
    parameter int DATA_W    = DATA_ROW_WIDTH,
    parameter int GRANT_W   = $clog2(NUM_CORES)
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic [NUM_CORES-1:0]        iCoreRequest,
    input  logic [NUM_CORES*ADDR_W-1:0] iCoreAddress,
    output logic [DATA_W-1:0]           oCoreData,
    output logic [NUM_CORES-1:0]        oCoreDataAvailable,
    output logic                        oTMEMRequest,
    output logic [ADDR_W-1:0]           oTMEMAddress,
    input  logic [DATA_W-1:0]           iTMEMData,
    input  logic                        iTMEMDataAvailable,
    output logic [GRANT_W-1:0]          oGrantId,
    output logic                        oBusy
);

    tmarb_state_e         state_q, state_d;
    logic [GRANT_W-1:0]   ptr_q, ptr_d;
    logic [GRANT_W-1:0]   grant_q, grant_d;
    logic [ADDR_W-1:0]    tmemAddr_q, tmemAddr_d;
    logic                 tmemReq_q, tmemReq_d;
    logic [DATA_W-1:0]    coreData_q, coreData_d;
    logic [NUM_CORES-1:0] coreAvail_q, coreAvail_d;
    logic                 abort_q, abort_d;

    logic                 selValid;
    logic [GRANT_W-1:0]   selIndex;
    logic [ADDR_W-1:0]    selAddr;
    logic                 grantedReq;

    rr_priority_select #(
        .N     (NUM_CORES),
        .IDX_W (GRANT_W)
    ) u_rr_select (
        .req_i         (iCoreRequest),
        .ptr_i         (ptr_q),
        .grant_valid_o (selValid),
        .grant_index_o (selIndex)
    );

    assign selAddr    = iCoreAddress[int'(selIndex)*ADDR_W +: ADDR_W];
    assign grantedReq = iCoreRequest[grant_q];

    // All registers clear on reset, which also drops oTMEMRequest at once and
    // abandons whatever TMEM transaction was in flight.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= TMARB_IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            tmemAddr_q  <= '0;
            tmemReq_q   <= 1'b0;
            coreData_q  <= '0;
            coreAvail_q <= '0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            tmemAddr_q  <= tmemAddr_d;
            tmemReq_q   <= tmemReq_d;
            coreData_q  <= coreData_d;
            coreAvail_q <= coreAvail_d;
            abort_q     <= abort_d;
        end
    end

    // A grant is withheld while TMEM still shows data from the last transfer.
    // A core that drops its request before data arrives aborts: the TMEM
    // transfer is allowed to finish but its data is never presented.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        tmemAddr_d  = tmemAddr_q;
        tmemReq_d   = tmemReq_q;
        coreData_d  = coreData_q;
        coreAvail_d = coreAvail_q;
        abort_d     = abort_q;

        case (state_q)
            TMARB_IDLE: begin
                if (selValid && !iTMEMDataAvailable) begin
                    grant_d    = selIndex;
                    tmemAddr_d = selAddr;
                    tmemReq_d  = 1'b1;
                    ptr_d      = GRANT_W'(wrapIncrement(int'(selIndex), NUM_CORES));
                    state_d    = TMARB_ISSUE_WAIT;
                end
            end
            TMARB_ISSUE_WAIT: begin
                if (!grantedReq) begin
                    abort_d = 1'b1;
                end
                if (iTMEMDataAvailable) begin
                    tmemReq_d = 1'b0;
                    if (abort_q || !grantedReq) begin
                        state_d = TMARB_DRAIN;
                    end else begin
                        coreData_d  = iTMEMData;
                        coreAvail_d = NUM_CORES'(1) << grant_q;
                        state_d     = TMARB_RESPOND;
                    end
                end
            end
            TMARB_RESPOND: begin
                if (!grantedReq) begin
                    coreAvail_d = '0;
                    state_d     = TMARB_DRAIN;
                end
            end
            TMARB_DRAIN: begin
                if (!iTMEMDataAvailable) begin
                    abort_d = 1'b0;
                    state_d = TMARB_IDLE;
                end
            end
            default: begin
                state_d = TMARB_IDLE;
            end
        endcase
    end

    assign oCoreData          = coreData_q;
    assign oCoreDataAvailable = coreAvail_q;
    assign oTMEMRequest       = tmemReq_q;
    assign oTMEMAddress       = tmemAddr_q;
    assign oGrantId           = grant_q;
    assign oBusy              = (state_q != TMARB_IDLE);

endmodule

// File: tb/tb_tmem_read_arbiter.sv
// Self-checking bench for tmem_read_arbiter: a vector table, hand-written
// corner sequences and randomized transactions against a round-robin model.
module tb_tmem_read_arbiter;

    localparam int N  = 4;
    localparam int AW = 96;
    localparam int DW = 96;
    localparam int GW = 2;

    logic            Clock;
    logic            Reset;
    logic [N-1:0]    coreReq;
    logic [N*AW-1:0] coreAddr;
    logic [DW-1:0]   coreData;
    logic [N-1:0]    coreAvail;
    logic            tmemReq;
    logic [AW-1:0]   tmemAddr;
    logic [DW-1:0]   tmemData;
    logic            tmemAvail;
    logic [GW-1:0]   grantId;
    logic            busy;

    int vectors;
    int miscompares;
    int modelPtr;
    logic [AW-1:0] modelAddr [N];

    typedef struct {
        logic [N-1:0]  mask;
        logic [AW-1:0] addrBase;
        int            latency;
        logic [DW-1:0] data;
        int            holdReq;
        int            expGrant;
    } vector_t;

    vector_t vecTable [10];

    tmem_read_arbiter #(
        .NUM_CORES (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .GRANT_W   (GW)
    ) dut (
        .Clock              (Clock),
        .Reset              (Reset),
        .iCoreRequest       (coreReq),
        .iCoreAddress       (coreAddr),
        .oCoreData          (coreData),
        .oCoreDataAvailable (coreAvail),
        .oTMEMRequest       (tmemReq),
        .oTMEMAddress       (tmemAddr),
        .iTMEMData          (tmemData),
        .iTMEMDataAvailable (tmemAvail),
        .oGrantId           (grantId),
        .oBusy              (busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic checkOutput(input string name, input logic [95:0] actual, input logic [95:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic setAddr(input int core, input logic [AW-1:0] value);
        coreAddr[core*AW +: AW] = value;
    endtask

    // First requester at or after ptr, searching upward with wrap-around.
    function automatic int modelPick(input logic [N-1:0] mask, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (mask[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic waitIdle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        checkOutput("idle reached", 96'(busy), 96'(0));
    endtask

    task automatic waitGrant(input int budget, input string name);
        int n = 0;
        logic sawAvail = 1'b0;
        while (!tmemReq && n < budget) begin
            step();
            if (coreAvail != '0) sawAvail = 1'b1;
            n++;
        end
        checkOutput({name, " grant reached"}, 96'(tmemReq), 96'(1));
        checkOutput({name, " no data before grant"}, 96'(sawAvail), 96'(0));
    endtask

    task automatic finishTransaction(input int core, input logic [DW-1:0] data, input string name);
        tmemData  = data;
        tmemAvail = 1'b1;
        step();
        tmemAvail = 1'b0;
        tmemData  = ~data;
        checkOutput({name, " coreAvail"}, 96'(coreAvail), 96'(4'b0001 << core));
        checkOutput({name, " coreData"}, coreData, data);
        coreReq[core] = 1'b0;
        step();
        checkOutput({name, " coreAvail cleared"}, 96'(coreAvail), 96'(0));
        waitIdle(10);
    endtask

    // One complete transaction from a table entry; all requests drop afterwards.
    task automatic applyStimulus(input vector_t v, input string name);
        logic [N-1:0] onehot;
        onehot = 4'b0001 << v.expGrant;
        for (int i = 0; i < N; i++) setAddr(i, v.addrBase + 96'(i));
        coreReq = v.mask;
        step();
        checkOutput({name, " tmemReq"}, 96'(tmemReq), 96'(1));
        checkOutput({name, " grantId"}, 96'(grantId), 96'(v.expGrant));
        checkOutput({name, " tmemAddr"}, tmemAddr, v.addrBase + 96'(v.expGrant));
        for (int i = 0; i < N; i++) setAddr(i, ~(v.addrBase + 96'(i)));
        for (int c = 0; c < v.latency; c++) step();
        checkOutput({name, " tmemAddr held"}, tmemAddr, v.addrBase + 96'(v.expGrant));
        tmemData  = v.data;
        tmemAvail = 1'b1;
        step();
        tmemAvail = 1'b0;
        tmemData  = ~v.data;
        checkOutput({name, " coreAvail"}, 96'(coreAvail), 96'(onehot));
        checkOutput({name, " coreData"}, coreData, v.data);
        checkOutput({name, " tmemReq dropped"}, 96'(tmemReq), 96'(0));
        for (int c = 0; c < v.holdReq; c++) begin
            step();
            checkOutput({name, " coreAvail held"}, 96'(coreAvail), 96'(onehot));
        end
        coreReq = '0;
        step();
        checkOutput({name, " coreAvail cleared"}, 96'(coreAvail), 96'(0));
        waitIdle(10);
        checkOutput({name, " coreData kept"}, coreData, v.data);
        modelPtr = (v.expGrant + 1) % N;
    endtask

    // Randomized transaction predicted by the round-robin model.
    task automatic serveModel(input bit rerequest, output int granted);
        int expG, lat, holdAvail, reqHold, lastCycle;
        logic [DW-1:0] data;
        logic [N-1:0]  onehot;
        coreReq = coreReq | 4'($urandom_range(0, 15));
        if (coreReq == '0) coreReq[$urandom_range(0, N-1)] = 1'b1;
        for (int i = 0; i < N; i++) begin
            modelAddr[i] = {$urandom, $urandom, $urandom};
            setAddr(i, modelAddr[i]);
        end
        expG   = modelPick(coreReq, modelPtr);
        onehot = 4'b0001 << expG;
        step();
        checkOutput("rand tmemReq", 96'(tmemReq), 96'(1));
        checkOutput("rand grantId", 96'(grantId), 96'(expG));
        checkOutput("rand tmemAddr", tmemAddr, modelAddr[expG]);
        modelPtr = (expG + 1) % N;
        for (int i = 0; i < N; i++) setAddr(i, {$urandom, $urandom, $urandom});
        lat = $urandom_range(0, 4);
        for (int c = 0; c < lat; c++) begin
            coreReq = coreReq | (4'($urandom_range(0, 15)) & ~onehot);
            step();
        end
        checkOutput("rand tmemReq held", 96'(tmemReq), 96'(1));
        checkOutput("rand tmemAddr held", tmemAddr, modelAddr[expG]);
        checkOutput("rand no early data", 96'(coreAvail), 96'(0));
        data      = {$urandom, $urandom, $urandom};
        tmemData  = data;
        tmemAvail = 1'b1;
        holdAvail = $urandom_range(1, 3);
        reqHold   = $urandom_range(0, 3);
        step();
        tmemData = ~data;
        checkOutput("rand coreAvail", 96'(coreAvail), 96'(onehot));
        checkOutput("rand coreData", coreData, data);
        checkOutput("rand tmemReq dropped", 96'(tmemReq), 96'(0));
        lastCycle = (holdAvail > reqHold + 1) ? holdAvail : reqHold + 1;
        for (int c = 1; c <= lastCycle; c++) begin
            if (c >= holdAvail) tmemAvail = 1'b0;
            if (c > reqHold) coreReq[expG] = 1'b0;
            step();
            checkOutput("rand coreAvail phase", 96'(coreAvail), (c <= reqHold) ? 96'(onehot) : 96'(0));
        end
        waitIdle(20);
        checkOutput("rand coreData kept", coreData, data);
        checkOutput("rand grantId kept", 96'(grantId), 96'(expG));
        if (rerequest || ($urandom_range(0, 1) == 1)) coreReq[expG] = 1'b1;
        granted = expG;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int g;
        int fairOrder [6] = '{0, 1, 2, 3, 0, 1};

        vectors     = 0;
        miscompares = 0;
        modelPtr    = 0;
        Reset       = 1'b1;
        coreReq     = '0;
        coreAddr    = '0;
        tmemData    = '0;
        tmemAvail   = 1'b0;

        vecTable[0] = '{4'b0100, 96'h0E,  3, 96'hABCD,                  2, 2};
        vecTable[1] = '{4'b1111, 96'h100, 0, 96'h1111_2222_3333,        0, 3};
        vecTable[2] = '{4'b1111, 96'h200, 1, 96'hDEAD_BEEF_0000_0001,   1, 0};
        vecTable[3] = '{4'b1111, 96'h300, 2, 96'hFFFF_0000_FFFF_0000,   0, 1};
        vecTable[4] = '{4'b1010, 96'h400, 1, 96'h0123_4567_89AB_CDEF,   0, 3};
        vecTable[5] = '{4'b1010, 96'h500, 4, 96'h5555_AAAA,             1, 1};
        vecTable[6] = '{4'b0001, 96'h600, 0, 96'h6,                     0, 0};
        vecTable[7] = '{4'b0011, 96'h700, 2, 96'h7777_7777_7777_7777,   0, 1};
        vecTable[8] = '{4'b0110, 96'h800, 1, 96'h8888,                  0, 2};
        vecTable[9] = '{4'b1001, 96'h900, 0, 96'h9_0000_0009,           0, 3};

        $display("[TB] reset values");
        step();
        step();
        checkOutput("reset tmemReq", 96'(tmemReq), 96'(0));
        checkOutput("reset coreAvail", 96'(coreAvail), 96'(0));
        checkOutput("reset coreData", coreData, 96'(0));
        checkOutput("reset tmemAddr", tmemAddr, 96'(0));
        checkOutput("reset grantId", 96'(grantId), 96'(0));
        checkOutput("reset busy", 96'(busy), 96'(0));
        Reset = 1'b0;
        step();
        checkOutput("post-reset busy", 96'(busy), 96'(0));

        $display("[TB] vector table");
        for (int v = 0; v < 10; v++) begin
            applyStimulus(vecTable[v], $sformatf("vec%0d", v));
        end

        $display("[TB] fairness with all cores requesting");
        coreReq = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            serveModel(1'b1, g);
            checkOutput($sformatf("fair order %0d", k), 96'(g), 96'(fairOrder[k]));
        end
        coreReq = '0;

        $display("[TB] reset during ISSUE_WAIT");
        coreReq = 4'b0010;
        step();
        checkOutput("rst grantId", 96'(grantId), 96'(1));
        step();
        #2;
        Reset = 1'b1;
        #1;
        checkOutput("rst async tmemReq", 96'(tmemReq), 96'(0));
        checkOutput("rst async busy", 96'(busy), 96'(0));
        coreReq = '0;
        step();
        Reset = 1'b0;
        step();
        checkOutput("rst coreAvail", 96'(coreAvail), 96'(0));
        checkOutput("rst grantId cleared", 96'(grantId), 96'(0));
        modelPtr = 0;
        applyStimulus('{4'b1111, 96'hA00, 1, 96'hA5A5, 0, 0}, "rst ptr zero");

        $display("[TB] abort during ISSUE_WAIT");
        coreReq = 4'b0001;
        step();
        checkOutput("abort grantId", 96'(grantId), 96'(0));
        coreReq = 4'b0010;
        step();
        step();
        checkOutput("abort tmemReq held", 96'(tmemReq), 96'(1));
        tmemData  = 96'hBAD0_BAD0;
        tmemAvail = 1'b1;
        step();
        tmemAvail = 1'b0;
        checkOutput("abort tmemReq dropped", 96'(tmemReq), 96'(0));
        checkOutput("abort coreAvail", 96'(coreAvail), 96'(0));
        checkOutput("abort drain busy", 96'(busy), 96'(1));
        waitGrant(10, "abort next");
        checkOutput("abort next grantId", 96'(grantId), 96'(1));
        finishTransaction(1, 96'h1234_5678, "abort next");

        $display("[TB] long TMEM data-available");
        coreReq = 4'b0001;
        step();
        checkOutput("long grantId", 96'(grantId), 96'(0));
        coreReq = 4'b0011;
        step();
        tmemData  = 96'hC0FFEE;
        tmemAvail = 1'b1;
        step();
        checkOutput("long coreAvail", 96'(coreAvail), 96'(4'b0001));
        checkOutput("long coreData", coreData, 96'hC0FFEE);
        coreReq = 4'b0010;
        for (int c = 0; c < 4; c++) begin
            step();
            checkOutput("long no grant", 96'(tmemReq), 96'(0));
        end
        tmemAvail = 1'b0;
        waitGrant(10, "long pending");
        checkOutput("long pending grantId", 96'(grantId), 96'(1));
        finishTransaction(1, 96'h4321, "long pending");

        $display("[TB] data-available high while idle");
        tmemAvail = 1'b1;
        coreReq   = 4'b0100;
        step();
        checkOutput("idle avail no grant", 96'(tmemReq), 96'(0));
        checkOutput("idle avail busy", 96'(busy), 96'(0));
        tmemAvail = 1'b0;
        step();
        checkOutput("idle avail grant", 96'(tmemReq), 96'(1));
        checkOutput("idle avail grantId", 96'(grantId), 96'(2));
        finishTransaction(2, 96'h77, "idle avail");
        modelPtr = 3;

        $display("[TB] randomized transactions");
        coreReq = '0;
        for (int k = 0; k < 40; k++) begin
            serveModel(1'b0, g);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
